// File: rtl/valu_result_writeback.sv
// valu_result_writeback: pairs issued destination addresses with in-order ALU results for register-file writeback
module valu_result_writeback #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  output logic                  iss_ready,
  input  logic [DATA_WIDTH-1:0] res_vec,
  input  logic                  res_valid,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_ready,
  output logic [CNT_WIDTH-1:0]  outstanding,
  output logic                  err_orphan
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_WIDTH-1:0] a_mem [DEPTH];
  logic [DATA_WIDTH-1:0] d_mem [DEPTH];
  logic [PW-1:0] a_wp_q, a_wp_d, a_rp_q, a_rp_d, d_wp_q, d_wp_d, d_rp_q, d_rp_d;
  logic [CNT_WIDTH-1:0] a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d, inflight;
  logic err_q, err_d, a_push, d_push, pop, orphan;
  assign iss_ready   = !rst && (a_cnt_q < CNT_WIDTH'(DEPTH));
  assign wb_valid    = d_cnt_q != '0;
  assign wb_addr     = a_mem[a_rp_q];
  assign wb_data     = d_mem[d_rp_q];
  assign outstanding = a_cnt_q;
  assign err_orphan  = err_q;
  always_comb begin
    inflight = a_cnt_q - d_cnt_q;
    a_push   = iss_valid && iss_ready;
    orphan   = res_valid && (inflight == '0);
    d_push   = res_valid && !orphan;
    pop      = wb_valid && wb_ready;
    a_wp_d   = a_push ? a_wp_q + PW'(1) : a_wp_q;
    d_wp_d   = d_push ? d_wp_q + PW'(1) : d_wp_q;
    a_rp_d   = pop ? a_rp_q + PW'(1) : a_rp_q;
    d_rp_d   = pop ? d_rp_q + PW'(1) : d_rp_q;
    a_cnt_d  = a_cnt_q + CNT_WIDTH'(a_push) - CNT_WIDTH'(pop);
    d_cnt_d  = d_cnt_q + CNT_WIDTH'(d_push) - CNT_WIDTH'(pop);
    err_d    = err_q || orphan;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_wp_q  <= '0;
      a_rp_q  <= '0;
      d_wp_q  <= '0;
      d_rp_q  <= '0;
      a_cnt_q <= '0;
      d_cnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      a_wp_q  <= a_wp_d;
      a_rp_q  <= a_rp_d;
      d_wp_q  <= d_wp_d;
      d_rp_q  <= d_rp_d;
      a_cnt_q <= a_cnt_d;
      d_cnt_q <= d_cnt_d;
      err_q   <= err_d;
    end
  end
  // storage is intentionally unreset; pointers alone define validity
  always_ff @(posedge clk) begin
    if (a_push) a_mem[a_wp_q] <= iss_addr;
    if (d_push) d_mem[d_wp_q] <= res_vec;
  end
endmodule

// File: tb/tb_valu_result_writeback.sv
// tb_valu_result_writeback: table vectors, directed corner sequences and random traffic against a queue model
module tb_valu_result_writeback;
  logic clk = 1'b0, rst, iss_valid, res_valid, wb_ready, iss_ready, wb_valid, err_orphan;
  logic [4:0] iss_addr, wb_addr;
  logic [63:0] res_vec, wb_data;
  logic [3:0] outstanding;
  int total = 0, bad = 0, dut_wbs = 0;
  logic [4:0] mq_a[$];
  logic [63:0] mq_d[$];
  logic m_err = 1'b0;
  typedef struct {
    logic r, iv; logic [4:0] ia; logic rv; logic [63:0] rd; logic wr;
    logic e_rdy, e_wv; logic [4:0] e_wa; logic [63:0] e_wd; logic [3:0] e_out; logic e_err;
  } vec_t;
  vec_t tbl[11];
  logic av[4];
  logic [63:0] ad[4];

  valu_result_writeback dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .res_vec(res_vec), .res_valid(res_valid), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_ready(wb_ready), .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic check_model();
    chk("iss_ready", 64'(iss_ready), 64'(!rst && mq_a.size() < 8));
    chk("wb_valid", 64'(wb_valid), 64'(mq_d.size() != 0));
    if (mq_d.size() != 0) begin
      chk("wb_addr", 64'(wb_addr), 64'(mq_a[0]));
      chk("wb_data", wb_data, mq_d[0]);
    end
    chk("outstanding", 64'(outstanding), 64'(mq_a.size()));
    chk("err_orphan", 64'(err_orphan), 64'(m_err));
  endtask

  task automatic model_update();
    int na, nd;
    logic orph;
    na = mq_a.size();
    nd = mq_d.size();
    orph = res_valid && (na == nd);
    if (rst) begin
      mq_a.delete();
      mq_d.delete();
      m_err = 1'b0;
    end else begin
      if (nd > 0 && wb_ready) begin
        void'(mq_a.pop_front());
        void'(mq_d.pop_front());
      end
      if (iss_valid && na < 8) mq_a.push_back(iss_addr);
      if (res_valid && !orph) mq_d.push_back(res_vec);
      if (orph) m_err = 1'b1;
    end
  endtask

  task automatic drive(input logic r, iv, input logic [4:0] ia, input logic rv, input logic [63:0] rd, input logic wr);
    @(negedge clk);
    rst = r; iss_valid = iv; iss_addr = ia; res_valid = rv; res_vec = rd; wb_ready = wr;
    #1;
  endtask

  task automatic cyc(input logic r, iv, input logic [4:0] ia, input logic rv, input logic [63:0] rd, input logic wr);
    drive(r, iv, ia, rv, rd, wr);
    check_model();
    if (wb_valid && wb_ready && !rst) dut_wbs++;
    model_update();
  endtask

  initial begin
    rst = 1'b1; iss_valid = 1'b0; iss_addr = '0; res_valid = 1'b0; res_vec = '0; wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    // r iv ia rv rd wr | rdy wv wa wd out err
    tbl[0]  = '{1'b1, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0,         1'b0, 1'b0, 5'd0, 64'd0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 5'd3, 1'b0, 64'd0, 1'b1,         1'b1, 1'b0, 5'd0, 64'd0, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b1,         1'b1, 1'b0, 5'd0, 64'd0, 4'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 5'd0, 1'b1, 64'hDEADBEEF, 1'b1,  1'b1, 1'b0, 5'd0, 64'd0, 4'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b1,         1'b1, 1'b1, 5'd3, 64'hDEADBEEF, 4'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b1,         1'b1, 1'b0, 5'd0, 64'd0, 4'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 5'd0, 1'b1, 64'h1234, 1'b1,      1'b1, 1'b0, 5'd0, 64'd0, 4'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b1,         1'b1, 1'b0, 5'd0, 64'd0, 4'd0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0,         1'b1, 1'b0, 5'd0, 64'd0, 4'd0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0,         1'b0, 1'b0, 5'd0, 64'd0, 4'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0,         1'b1, 1'b0, 5'd0, 64'd0, 4'd0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].iv, tbl[i].ia, tbl[i].rv, tbl[i].rd, tbl[i].wr);
      chk($sformatf("tbl%0d_rdy", i), 64'(iss_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_wv", i), 64'(wb_valid), 64'(tbl[i].e_wv));
      if (tbl[i].e_wv) begin
        chk($sformatf("tbl%0d_wa", i), 64'(wb_addr), 64'(tbl[i].e_wa));
        chk($sformatf("tbl%0d_wd", i), wb_data, tbl[i].e_wd);
      end
      chk($sformatf("tbl%0d_out", i), 64'(outstanding), 64'(tbl[i].e_out));
      chk($sformatf("tbl%0d_err", i), 64'(err_orphan), 64'(tbl[i].e_err));
      model_update();
    end
    // fill to DEPTH with writeback stalled, then drain in order
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 5'(i), 1'b0, 64'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0);
    chk("fill_rdy", 64'(iss_ready), 64'd0);
    chk("fill_out", 64'(outstanding), 64'd8);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 5'd0, 1'b1, 64'hA000 + 64'(i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b1);
      chk("drain_addr", 64'(wb_addr), 64'(i));
      chk("drain_data", wb_data, 64'hA000 + 64'(i));
      if (i == 1) chk("rdy_after_wb", 64'(iss_ready), 64'd1);
    end
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b1);
    // stall hold while more results land behind the head
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'(10 + i), 1'b0, 64'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 64'hB0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 5'd0, k == 1 || k == 3, k == 1 ? 64'hB1 : 64'hB2, 1'b0);
      chk("hold_addr", 64'(wb_addr), 64'd10);
      chk("hold_data", wb_data, 64'hB0);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b1);
      chk("hold_seq_addr", 64'(wb_addr), 64'(10 + k));
      chk("hold_seq_data", wb_data, 64'hB0 + 64'(k));
    end
    // streaming: 40 issues, results 6 cycles later
    dut_wbs = 0;
    for (int c = 0; c < 49; c++)
      cyc(1'b0, c < 40, 5'(c), c >= 6 && c < 46, 64'hC000 + 64'(c) - 64'd6, 1'b1);
    chk("stream_wbs", 64'(dut_wbs), 64'd40);
    chk("stream_err", 64'(err_orphan), 64'd0);
    chk("stream_out", 64'(outstanding), 64'd0);
    // reset mid-flight
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'(20 + i), 1'b0, 64'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 64'hDD1, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0);
    chk("rst_wv", 64'(wb_valid), 64'd0);
    chk("rst_out", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err_orphan), 64'd0);
    chk("rst_rdy", 64'(iss_ready), 64'd1);
    // random traffic through a 4-stage ALU emulation
    for (int k = 0; k < 4; k++) begin av[k] = 1'b0; ad[k] = '0; end
    for (int c = 0; c < 3000; c++) begin
      logic r, iv, wr, rv, go;
      logic [63:0] rd;
      r  = $urandom_range(0, 199) == 0;
      iv = $urandom_range(0, 2) != 0;
      wr = $urandom_range(0, 3) != 0;
      rv = av[3];
      rd = ad[3];
      if (!rv && $urandom_range(0, 299) == 0) begin rv = 1'b1; rd = {$urandom, $urandom}; end
      go = !r && iv && mq_a.size() < 8;
      cyc(r, iv, 5'($urandom), rv, rd, wr);
      for (int k = 3; k > 0; k--) begin av[k] = r ? 1'b0 : av[k-1]; ad[k] = ad[k-1]; end
      av[0] = go;
      ad[0] = {$urandom, $urandom};
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/valu_result_writeback.md
# valu_result_writeback

Receive-side companion to the fixed-latency vector ALU pipelines. It pairs each issued destination register address with the ALU result that returns some cycles later. It buffers the pairs in order and presents them to the vector register file write port on a valid/ready handshake. It also provides issue-side flow control, because the ALU pipelines have no back-pressure and the results must always have a slot to land in.

## Interface
- DATA_WIDTH, 64: result width; must match the ALU RESP_DATA_WIDTH.
- ADDR_WIDTH, 5: destination register address width.
- DEPTH, 8: maximum outstanding operations (issued but not yet written back); power of two, ≥2.
- CNT_WIDTH, $clog2(DEPTH+1): width of the occupancy counter.

Clocking and reset: one clock; reset is synchronous and active-high.

- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- iss_valid  in  1  the issue stage is sending an op to an ALU this cycle.
- iss_addr  in  ADDR_WIDTH  destination address of that op.
- iss_ready  out  1  issue permitted; the issue stage must not assert in_valid toward the ALU unless iss_valid & iss_ready.
- res_vec  in  DATA_WIDTH  ALU out_vec.
- res_valid  in  1  ALU out_valid; cannot be stalled.
- wb_valid  out  1  head entry available for writeback.
- wb_addr  out  ADDR_WIDTH  head entry destination address.
- wb_data  out  DATA_WIDTH  head entry result.
- wb_ready  in  1  register file accepts the head entry.
- outstanding  out  CNT_WIDTH  count of addresses held (issued, not yet written back).
- err_orphan  out  1  sticky: a result arrived with no pending issue.

## Operation
- Two circular FIFOs of DEPTH entries each, with separate read/write pointers and counts:
  - The address FIFO (A) is pushed on every issue handshake (iss_valid & iss_ready).
  - The data FIFO (D) is pushed on res_valid.
  - Both FIFOs pop together on a writeback handshake (wb_valid & wb_ready).
- Results return in issue order (fixed-latency ALUs), so the head of D always belongs to the head of A.
- Invariant: D count ≤ A count ≤ DEPTH. In-flight count = A count − D count.
- iss_ready = !rst && (A count < DEPTH), computed from registered state only; it has no combinational path from iss_valid or wb_ready.
- wb_valid = D count != 0. wb_addr and wb_data are the A and D heads, read combinationally from registered storage.
- outstanding = A count.
- Orphan result (res_valid while in-flight count == 0):
  - The result is dropped, with no push and no pointer change.
  - err_orphan is set and stays high until rst.
- Simultaneous events in one cycle:
  - Issue, result and writeback may all coincide. Each count updates by (+push − pop).
  - An issue at A count == DEPTH is impossible because iss_ready is 0.
  - A writeback in the same cycle does not raise iss_ready until the next cycle.
- Pointers wrap modulo DEPTH.
- wb_addr and wb_data must stay stable while wb_valid & !wb_ready.
- Storage arrays are not reset; pointers, counts and flags are.

## Timing
- Reset values: iss_ready 0 while rst is high, then 1 in the first cycle after rst deasserts. wb_valid 0, outstanding 0, err_orphan 0. wb_addr and wb_data are don't-care while wb_valid is 0.
- Latency from result to writeback: res_valid sampled at edge t gives wb_valid = 1 in cycle t+1 (after that edge) if D was empty.
- Issue handshake at edge t: outstanding increments after that edge.
- Writeback handshake at edge t:
  - The next entry is presented in cycle t+1.
  - If D becomes empty, wb_valid = 0 after the edge.
- Full throughput: one issue, one result and one writeback per cycle are sustainable indefinitely.
- rst asserted mid-operation: all pending entries are discarded and counts cleared at that edge. Results from the ALU arriving after reset are orphans unless new issues precede them; the ALU is also reset by the same rst.

## Test plan
- Single op, DEPTH=8: issue addr 3, then res_valid with 0xDEADBEEF two cycles later, wb_ready=1.
  - wb_valid rises the cycle after the result, with wb_addr=3 and wb_data=0xDEADBEEF.
  - outstanding goes 0→1→0.
- Fill: wb_ready=0, issue addrs 0..7 on consecutive cycles.
  - iss_ready drops to 0 in the cycle after the 8th issue; outstanding=8.
  - Return 8 results, then assert wb_ready: writebacks are addrs 0..7 in order with matching data.
  - iss_ready returns to 1 the cycle after the first writeback.
- Stall hold: with wb_valid=1, hold wb_ready=0 for 5 cycles while 2 more results arrive.
  - wb_addr and wb_data stay unchanged.
  - Subsequent writebacks preserve order.
- Streaming: issue every cycle for 40 cycles, results returning 6 cycles later, wb_ready=1.
  - One writeback per cycle; no loss; pointers wrap ≥4 times; err_orphan stays 0.
- Orphan: with no issue pending, pulse res_valid with 0x1234.
  - err_orphan goes to 1 and stays 1; wb_valid stays 0; outstanding stays 0.
- Reset mid-flight: issue 3 ops, deliver 1 result, assert rst for 1 cycle.
  - Afterwards wb_valid=0, outstanding=0, err_orphan=0, iss_ready=1.
